ddr_init_seq: RTL and testbench

Hardware DDR SDRAM bring-up sequencer and Wishbone master that drives the CSR bridge (`csrbrg`) upstream of `ddram`. It replays the fixed controller/SDRAM initialisation sequence that the bench currently issues by hand: bypass enable, delay reset, CKE, precharge, EMR/MR loads, auto-refresh, DLL enable, hand-over. After a power-up wait it issues 18 CSR writes with programmed gaps, then raises `done` so FML traffic through `fmlbrg_b` / `interface_ddr_16_bit` may start.

---
 rtl/ddr_init_seq.sv | 201 ++++++++++++++++++++
 tb/tb_ddr_init_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_init_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ddr_init_seq : DDR SDRAM bring-up sequencer, Wishbone write master that   |
// |                replays the controller/SDRAM init steps into csrbrg.       |
// | Optional feature macro: DDRINIT_TIMEOUT_EN (ack timeout + ERR state).     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ddr_init_seq #(
   parameter logic [31:0] csr_base        = 32'h4000_2000,
   parameter logic [15:0] power_up_cycles = 16'd5150,
   parameter logic [7:0]  ack_timeout     = 8'd255
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        restart,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   input  logic        wb_ack_i,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [4:0]  step
);

   typedef enum logic [2:0] {
      S_PWR  = 3'd0,
      S_WR   = 3'd1,
      S_GAP  = 3'd2,
      S_DONE = 3'd3
`ifdef DDRINIT_TIMEOUT_EN
      , S_ERR = 3'd4
`endif
   } state_t;

   typedef struct packed {
      logic [3:0]  off;
      logic [31:0] dat;
      logic [7:0]  gap;
   } rom_t;

   localparam logic [4:0] LAST_STEP = 5'd17;
   localparam logic [3:0] OFF_CTRL  = 4'h0;
   localparam logic [3:0] OFF_CMD   = 4'h4;
   localparam logic [3:0] OFF_DLY   = 4'hc;

   // The CMD<-0x8 entries (steps 4,6,...,16) are the default arm.
   function automatic rom_t rom_entry(input logic [4:0] idx);
      rom_t e;
      e = '{OFF_CMD, 32'h0000_0008, 8'd1};
      case (idx)
         5'd0:    e = '{OFF_CTRL, 32'h0000_0001, 8'd1};
         5'd1:    e = '{OFF_DLY,  32'h0000_0001, 8'd1};
         5'd2:    e = '{OFF_CTRL, 32'h0000_0007, 8'd1};
         5'd3:    e = '{OFF_CMD,  32'h0000_400b, 8'd1};
         5'd5:    e = '{OFF_CMD,  32'h0002_000f, 8'd1};
         5'd7:    e = '{OFF_CMD,  32'h0000_123f, 8'd100};
         5'd9:    e = '{OFF_CMD,  32'h0000_400b, 8'd1};
         5'd11:   e = '{OFF_CMD,  32'h0000_000d, 8'd4};
         5'd13:   e = '{OFF_CMD,  32'h0000_000d, 8'd4};
         5'd15:   e = '{OFF_CMD,  32'h0000_021f, 8'd100};
         5'd17:   e = '{OFF_CTRL, 32'h0000_0004, 8'd1};
         default: ;
      endcase
      return e;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [4:0]  step_q, step_d;
   logic        stb_q, stb_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   rom_t        cur, nxt;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      step_d  = step_q;
      cur     = rom_entry(step_q);
      case (state_q)
         S_PWR: begin
            if (cnt_q == power_up_cycles) begin
               state_d = S_WR;
               cnt_d   = 16'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_WR: begin
            if (wb_ack_i) begin
               state_d = S_GAP;
               cnt_d   = 16'd1;
            end
`ifdef DDRINIT_TIMEOUT_EN
            else if (cnt_q == {8'd0, ack_timeout}) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         S_GAP: begin
            // cnt_q equals the number of low-strobe cycles already spent.
            if (cnt_q == {8'd0, cur.gap}) begin
               if (step_q == LAST_STEP) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WR;
                  step_d  = step_q + 5'd1;
                  cnt_d   = 16'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DONE: begin
            if (restart) begin
               state_d = S_WR;
               step_d  = 5'd0;
               cnt_d   = 16'd1;
            end
         end
`ifdef DDRINIT_TIMEOUT_EN
         S_ERR: begin
            if (restart) begin
               state_d = S_WR;
               step_d  = 5'd0;
               cnt_d   = 16'd1;
            end
         end
`endif
         default: state_d = S_PWR;
      endcase

      // Outputs are precomputed from the next state so they leave flops.
      nxt    = rom_entry(step_d);
      stb_d  = (state_d == S_WR);
      adr_d  = stb_d ? (csr_base + {28'd0, nxt.off}) : 32'd0;
      dat_d  = stb_d ? nxt.dat : 32'd0;
      busy_d = (state_d == S_PWR) || (state_d == S_WR) || (state_d == S_GAP);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q <= S_PWR;
         cnt_q   <= 16'd0;
         step_q  <= 5'd0;
         stb_q   <= 1'b0;
         adr_q   <= 32'd0;
         dat_q   <= 32'd0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         stb_q   <= stb_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef DDRINIT_TIMEOUT_EN
   logic error_q;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         error_q <= 1'b0;
      end else begin
         error_q <= (state_d == S_ERR);
      end
   end

   assign error = error_q;
`else
   logic unused_ack_timeout;
   assign unused_ack_timeout = ^ack_timeout;
   assign error = 1'b0;
`endif

   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = 4'hf;
   assign wb_cyc_o = stb_q;
   assign wb_stb_o = stb_q;
   assign wb_we_o  = stb_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign step     = step_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_init_seq.sv
`default_nettype none
// Bench for ddr_init_seq: randomized ack latency and spurious acks, checked
// against a table-plus-arithmetic model of the init sequence timing.
module tb_ddr_init_seq;

   localparam int N = 5150;

   logic        clk;
   logic        rst_n;
   logic        restart;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic        wb_ack_i;
   logic        busy;
   logic        done;
   logic        error;
   logic [4:0]  step;

   ddr_init_seq dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .restart   (restart),
      .wb_adr_o  (wb_adr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_sel_o  (wb_sel_o),
      .wb_cyc_o  (wb_cyc_o),
      .wb_stb_o  (wb_stb_o),
      .wb_we_o   (wb_we_o),
      .wb_ack_i  (wb_ack_i),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .step      (step)
   );

   int exp_off [18] = '{'h0, 'hc, 'h0, 'h4, 'h4, 'h4, 'h4, 'h4, 'h4,
                        'h4, 'h4, 'h4, 'h4, 'h4, 'h4, 'h4, 'h4, 'h0};
   int exp_dat [18] = '{'h1, 'h1, 'h7, 'h400b, 'h8, 'h2000f, 'h8, 'h123f, 'h8,
                        'h400b, 'h8, 'hd, 'h8, 'hd, 'h8, 'h21f, 'h8, 'h4};
   int exp_gap [18] = '{1, 1, 1, 1, 1, 1, 1, 100, 1, 1, 1, 4, 1, 4, 1, 100, 1, 1};

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] wr_adr [$];
   logic [31:0] wr_dat [$];
   int          wr_rise[$];
   int          wr_fall[$];
   int          lat_q  [$];
   int          done_cyc = -1;

   int lat_fixed = 1;
   bit lat_rand  = 0;
   bit spur_en   = 0;
   int hold_step = -1;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Ack responder: latency counted in edges after the strobe rises.
   initial begin
      int hi_cnt;
      int cur_lat;
      hi_cnt   = 0;
      cur_lat  = 1;
      wb_ack_i = 1'b0;
      forever begin
         @(negedge clk);
         wb_ack_i = 1'b0;
         if (wb_stb_o === 1'b1) begin
            if (hi_cnt == 0) begin
               cur_lat = lat_rand ? int'($urandom_range(1, 10)) : lat_fixed;
               lat_q.push_back(cur_lat);
            end
            hi_cnt++;
            if (hi_cnt == cur_lat && int'(step) != hold_step) wb_ack_i = 1'b1;
         end else begin
            hi_cnt = 0;
            if (spur_en && $urandom_range(0, 3) == 0) wb_ack_i = 1'b1;
         end
      end
   end

   // Bus monitor: records writes and checks handshake properties each cycle.
   initial begin
      logic        prev_stb;
      logic        prev_done;
      logic [31:0] hold_adr;
      logic [31:0] hold_dat;
      prev_stb  = 1'b0;
      prev_done = 1'b0;
      hold_adr  = '0;
      hold_dat  = '0;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 || cyc > 2) begin
            chk("ctl_bits", {26'd0, wb_cyc_o, wb_we_o, wb_sel_o},
                wb_stb_o ? 32'h3f : 32'h0f);
            if (wb_stb_o && !prev_stb) begin
               chk("step_at_rise", 32'(step), 32'(wr_adr.size()));
               wr_adr.push_back(wb_adr_o);
               wr_dat.push_back(wb_dat_o);
               wr_rise.push_back(cyc);
               hold_adr = wb_adr_o;
               hold_dat = wb_dat_o;
            end else if (wb_stb_o) begin
               chk("adr_stable", wb_adr_o, hold_adr);
               chk("dat_stable", wb_dat_o, hold_dat);
            end
            if (!wb_stb_o) begin
               chk("adr_idle_zero", wb_adr_o, 32'd0);
               chk("dat_idle_zero", wb_dat_o, 32'd0);
               if (prev_stb) wr_fall.push_back(cyc);
            end
            if (done && !prev_done) begin
               done_cyc = cyc;
               chk("busy_at_done", 32'(busy), 32'd0);
               chk("step_at_done", 32'(step), 32'd17);
            end
            prev_stb  = wb_stb_o;
            prev_done = done;
         end
      end
   end

   task automatic clear_log();
      wr_adr.delete();
      wr_dat.delete();
      wr_rise.delete();
      wr_fall.delete();
      lat_q.delete();
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done), 32'd1);
   endtask

   task automatic wait_step(input string tag, input int s, input int budget);
      int n = 0;
      while (!(wb_stb_o === 1'b1 && int'(step) == s) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(wb_stb_o === 1'b1 && int'(step) == s), 32'd1);
   endtask

   task automatic pulse_restart(output int at);
      restart = 1'b1;
      at      = cyc + 1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   // Expected rise of write i = start + sum over earlier writes of (latency + gap).
   task automatic verify_run(input string tag, input int c_start);
      int t;
      t = c_start;
      chk({tag, "_nwrites"}, 32'(wr_adr.size()), 32'd18);
      chk({tag, "_nlat"}, 32'(lat_q.size()), 32'd18);
      for (int i = 0; i < 18; i++) begin
         if (i < wr_adr.size() && i < lat_q.size()) begin
            chk({tag, "_adr"}, wr_adr[i], 32'h4000_2000 + 32'(exp_off[i]));
            chk({tag, "_dat"}, wr_dat[i], 32'(exp_dat[i]));
            chk({tag, "_rise"}, 32'(wr_rise[i]), 32'(t));
            t = t + lat_q[i] + exp_gap[i];
         end
      end
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(t));
   endtask

   initial begin
      int c0;
      int cr;
      int n;
      rst_n   = 1'b0;
      restart = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_stb", 32'(wb_stb_o), 32'd0);
      chk("rst_adr", wb_adr_o, 32'd0);
      chk("rst_dat", wb_dat_o, 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_step", 32'(step), 32'd0);

      // Run 1: ack one cycle after stb.
      rst_n = 1'b1;
      c0    = cyc + 1;
      wait_done("run1_done", N + 1000);
      verify_run("run1", c0 + N);
      chk("run1_total", 32'(done_cyc), 32'(c0 + N + 240));
      repeat (50) @(negedge clk);
      chk("run1_no_extra", 32'(wr_adr.size()), 32'd18);
      chk("run1_done_hold", 32'(done), 32'd1);

      // Run 2: restart from DONE, random latency, spurious acks, ignored restart.
      clear_log();
      lat_rand = 1;
      spur_en  = 1;
      pulse_restart(cr);
      wait_step("run2_step5", 5, 500);
      pulse_restart(n);
      wait_done("run2_done", 2000);
      verify_run("run2", cr);
      if (wr_rise.size() > 8 && wr_fall.size() > 7)
         chk("run2_gap100", 32'(wr_rise[8] - wr_fall[7]), 32'd100);
      else
         chk("run2_gap100_log", 32'(wr_rise.size()), 32'd18);

      // Run 3: reset pulse during step 9's strobe.
      clear_log();
      lat_rand  = 0;
      lat_fixed = 3;
      spur_en   = 0;
      pulse_restart(cr);
      wait_step("run3_step9", 9, 500);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_stb", 32'(wb_stb_o), 32'd0);
      chk("midrst_step", 32'(step), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd1);
      chk("midrst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      c0    = cyc + 1;
      @(negedge clk);
      clear_log();
      wait_done("run3_done", N + 1000);
      verify_run("run3", c0 + N);

`ifdef DDRINIT_TIMEOUT_EN
      // Ack withheld at step 3 until the timeout fires.
      clear_log();
      lat_fixed = 1;
      hold_step = 3;
      pulse_restart(cr);
      wait_step("to_step3", 3, 500);
      n = 0;
      while (error !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("to_error", 32'(error), 32'd1);
      chk("to_step", 32'(step), 32'd3);
      chk("to_done", 32'(done), 32'd0);
      chk("to_busy", 32'(busy), 32'd0);
      chk("to_stb", 32'(wb_stb_o), 32'd0);
      if (wr_rise.size() > 3 && wr_fall.size() > 3)
         chk("to_stb_len", 32'(wr_fall[3] - wr_rise[3]), 32'd255);
      else
         chk("to_log", 32'(wr_fall.size()), 32'd4);
      hold_step = -1;
      clear_log();
      pulse_restart(cr);
      chk("to_error_clr", 32'(error), 32'd0);
      wait_done("to_rerun_done", 2000);
      verify_run("to_rerun", cr);
`endif

      // Restart coincident with reset: reset wins, full power-up wait follows.
      rst_n   = 1'b0;
      restart = 1'b1;
      @(negedge clk);
      rst_n   = 1'b1;
      restart = 1'b0;
      c0      = cyc + 1;
      chk("rr_done", 32'(done), 32'd0);
      chk("rr_busy", 32'(busy), 32'd1);
      chk("rr_step", 32'(step), 32'd0);
      chk("rr_stb", 32'(wb_stb_o), 32'd0);
      @(negedge clk);
      clear_log();
      n = 0;
      while (wr_rise.size() == 0 && n < N + 200) begin
         @(negedge clk);
         n++;
      end
      chk("rr_first_seen", 32'(wr_rise.size() > 0), 32'd1);
      if (wr_rise.size() > 0) begin
         chk("rr_first_rise", 32'(wr_rise[0]), 32'(c0 + N));
         chk("rr_first_adr", wr_adr[0], 32'h4000_2000);
         chk("rr_first_dat", wr_dat[0], 32'h1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
